cyclic_shift_pipe: RTL and testbench

CYCLIC_SHIFT_PIPE -- requirements
Module: cyclic_shift_pipe

---
 rtl/cyclic_shift_pipe_pkg.sv | 24 ++
 rtl/cyclic_shift_stage.sv | 52 +++++
 rtl/cyclic_shift_pipe.sv | 79 +++++++
 tb/tb_cyclic_shift_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cyclic_shift_pipe_pkg.sv
// csnc_pkg: direction type and rotate helpers shared by the cyclic shifter
package csnc_pkg;

    typedef enum logic {SHIFT_RIGHT = 1'b0, SHIFT_LEFT = 1'b1} shift_dir_e;

    // Helpers work on a fixed wide vector so one definition serves every WIDTH up to MAXW
    localparam int MAXW = 32;
    localparam int IDXW = $clog2(MAXW);

    // out[i] = x[(i + s) mod w] for the low w bits
    function automatic logic [MAXW-1:0] rot_right(input logic [MAXW-1:0] x, input int w, input int s);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++)
            if (i < w) r[IDXW'(i)] = x[IDXW'((i + s) % w)];
        return r;
    endfunction

    // out[(i + s) mod w] = x[i], expressed as the complementary right rotation
    function automatic logic [MAXW-1:0] rot_left(input logic [MAXW-1:0] x, input int w, input int s);
        return rot_right(x, w, (w - (s % w)) % w);
    endfunction

endpackage

// File: rtl/cyclic_shift_stage.sv
// cyclic_shift_stage: one conditional rotate-by-STEP followed by the pipeline register
module cyclic_shift_stage
    import csnc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP = 1,
    localparam int SHW = $clog2(WIDTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  shift_dir_e       in_dir,
    input  logic             in_last,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output shift_dir_e       out_dir,
    output logic             out_last
);

    logic [MAXW-1:0]  wide;
    logic [WIDTH-1:0] rot;

    // rotate by STEP in the beat's direction only when this stage's shamt bit is set
    always_comb begin
        wide = MAXW'(in_data);
        rot  = !en ? in_data
             : WIDTH'(in_dir == SHIFT_LEFT ? rot_left(wide, WIDTH, STEP) : rot_right(wide, WIDTH, STEP));
    end

    // capture the beat when the whole pipe advances; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_dir   <= SHIFT_RIGHT;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_data  <= rot;
            out_shamt <= in_shamt;
            out_dir   <= in_dir;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/cyclic_shift_pipe.sv
// cyclic_shift_pipe: pipelined barrel rotator, one stage per shamt bit; optional frame XOR accumulator via CYCLIC_SHIFT_XOR_ACC_EN
module cyclic_shift_pipe
    import csnc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_dir,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef CYCLIC_SHIFT_XOR_ACC_EN
    output logic [WIDTH-1:0]   out_acc,
`endif
    output logic               out_last
);

    localparam int STAGES = $clog2(WIDTH);

    logic               adv;
    logic               v  [STAGES+1];
    logic [WIDTH-1:0]   d  [STAGES+1];
    logic [SHAMT_W-1:0] sh [STAGES+1];
    shift_dir_e         dr [STAGES+1];
    logic               l  [STAGES+1];

    // every stage moves in lockstep; a full pipe only stalls when the output is blocked
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign v[0]  = in_valid;
    assign d[0]  = in_data;
    assign sh[0] = in_shamt;
    assign dr[0] = shift_dir_e'(in_dir);
    assign l[0]  = in_last;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cyclic_shift_stage #(.WIDTH(WIDTH), .STEP(1 << k)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .en        (sh[k][k]),
            .in_valid  (v[k]),
            .in_data   (d[k]),
            .in_shamt  (sh[k]),
            .in_dir    (dr[k]),
            .in_last   (l[k]),
            .out_valid (v[k+1]),
            .out_data  (d[k+1]),
            .out_shamt (sh[k+1]),
            .out_dir   (dr[k+1]),
            .out_last  (l[k+1])
        );
    end

    assign out_valid = v[STAGES];
    assign out_data  = d[STAGES];
    assign out_last  = l[STAGES];

`ifdef CYCLIC_SHIFT_XOR_ACC_EN
    logic [WIDTH-1:0] acc;

    // fold each delivered beat into the frame sum, restarting once the last beat leaves
    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else if (out_valid && out_ready) acc <= out_last ? '0 : acc ^ out_data;
    end

    assign out_acc = out_valid ? acc ^ out_data : acc;
`endif

endmodule

// File: tb/tb_cyclic_shift_pipe.sv
// tb_cyclic_shift_pipe: directed checks of the cyclic_shift_pipe rotator (WIDTH=4 and WIDTH=5)
module tb_cyclic_shift_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, in_dir, in_last, out_valid, out_ready, out_last;
    logic [3:0] in_data, out_data;
    logic [1:0] in_shamt;
    logic       f_in_valid, f_in_ready, f_in_dir, f_in_last, f_out_valid, f_out_ready, f_out_last;
    logic [4:0] f_in_data, f_out_data;
    logic [2:0] f_in_shamt;
`ifdef CYCLIC_SHIFT_XOR_ACC_EN
    logic [3:0] out_acc;
    logic [4:0] f_out_acc;
`endif

    int compared = 0;
    int mismatched = 0;

    cyclic_shift_pipe #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
        .in_dir(in_dir), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef CYCLIC_SHIFT_XOR_ACC_EN
        .out_acc(out_acc),
`endif
        .out_last(out_last)
    );

    cyclic_shift_pipe #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data), .in_shamt(f_in_shamt),
        .in_dir(f_in_dir), .in_last(f_in_last),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
`ifdef CYCLIC_SHIFT_XOR_ACC_EN
        .out_acc(f_out_acc),
`endif
        .out_last(f_out_last)
    );

    logic [3:0] rv_data  [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0110, 4'b1001, 4'b0010};
    logic [1:0] rv_shamt [6] = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       rv_dir   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] rv_exp   [6] = '{4'b1000, 4'b0001, 4'b0001, 4'b1100, 4'b0110, 4'b0100};
    logic [3:0] bb_exp   [8] = '{4'h8, 4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4};
    logic [4:0] w5_data  [3] = '{5'b00001, 5'b00001, 5'b00011};
    logic [2:0] w5_shamt [3] = '{3'd7, 3'd5, 3'd6};
    logic       w5_dir   [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0] w5_exp   [3] = '{5'b01000, 5'b00001, 5'b00110};

    task automatic idle();
        in_valid = 0; in_data = '0; in_shamt = '0; in_dir = 0; in_last = 0; out_ready = 1;
        f_in_valid = 0; f_in_data = '0; f_in_shamt = '0; f_in_dir = 0; f_in_last = 0; f_out_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        compared++; if (out_data !== 4'b0) begin mismatched++; $display("FAIL reset_out_data got %b want 0000", out_data); end
        compared++; if (out_last !== 1'b0) begin mismatched++; $display("FAIL reset_out_last got %b want 0", out_last); end
        compared++; if (f_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_w5_out_valid got %b want 0", f_out_valid); end
`ifdef CYCLIC_SHIFT_XOR_ACC_EN
        compared++; if (out_acc !== 4'b0) begin mismatched++; $display("FAIL reset_out_acc got %h want 0", out_acc); end
`endif
        rst = 0;
        @(posedge clk); #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        in_valid = 1; in_data = 4'b0001; in_shamt = 2'd1; in_dir = 0; in_last = 0;
        @(posedge clk); #1;
        in_valid = 0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL latency_early got out_valid %b want 0", out_valid); end
        @(posedge clk); #1;
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL latency_valid got %b want 1", out_valid); end
        compared++; if (out_data !== 4'b1000) begin mismatched++; $display("FAIL latency_data got %b want 1000", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_rotate();
        int j = 0, got = 0;
        for (int c = 0; c < 16; c++) begin
            if (j < 6 && c != 3) begin
                in_valid = 1; in_data = rv_data[j]; in_shamt = rv_shamt[j]; in_dir = rv_dir[j]; j++;
            end else in_valid = 0;
            @(posedge clk); #1;
            if (out_valid) begin
                compared++;
                if (got >= 6) begin mismatched++; $display("FAIL rotate_extra_beat got %b want none", out_data); end
                else if (out_data !== rv_exp[got]) begin mismatched++; $display("FAIL rotate_%0d got %b want %b", got, out_data, rv_exp[got]); end
                got++;
            end
        end
        compared++; if (got != 6) begin mismatched++; $display("FAIL rotate_count got %0d want 6", got); end
    endtask

    task automatic test_back_to_back();
        int j = 0, got = 0;
        logic fi, fo;
        for (int c = 0; c < 40 && got < 8; c++) begin
            out_ready = !(c >= 4 && c < 7);
            in_valid = j < 8; in_data = 4'(j + 1); in_shamt = 2'd1; in_dir = 0; in_last = (j == 7);
            #1;
            if (!out_ready) begin
                compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
            end
            if (out_valid) begin
                compared++;
                if (got >= 8) begin mismatched++; $display("FAIL b2b_extra_beat got %h want none", out_data); end
                else if (out_data !== bb_exp[got] || out_last !== (got == 7)) begin
                    mismatched++; $display("FAIL b2b_%0d got %h/%b want %h/%b", got, out_data, out_last, bb_exp[got], got == 7);
                end
            end
            fi = in_valid && in_ready;
            fo = out_valid && out_ready;
            @(posedge clk);
            if (fi) j++;
            if (fo) got++;
            #1;
        end
        idle();
        compared++; if (got != 8 || j != 8) begin mismatched++; $display("FAIL b2b_count got %0d/%0d want 8/8", got, j); end
    endtask

    task automatic test_reset_flush();
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1; in_data = 4'b0011; in_shamt = 2'd0; in_dir = 0;
        @(posedge clk); #1;
        in_data = 4'b0110;
        @(posedge clk); #1;
        in_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_ghost_%0d got %h want no beat", c, out_data); end
        end
        in_valid = 1; in_data = 4'b0001; in_shamt = 2'd2; in_dir = 0;
        @(posedge clk); #1;
        in_valid = 0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_next_early got %b want 0", out_valid); end
        @(posedge clk); #1;
        compared++; if (out_valid !== 1'b1 || out_data !== 4'b0100) begin
            mismatched++; $display("FAIL flush_next got %b/%b want 1/0100", out_valid, out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width5();
        int j = 0, got = 0;
        for (int c = 0; c < 12; c++) begin
            if (j < 3) begin
                f_in_valid = 1; f_in_data = w5_data[j]; f_in_shamt = w5_shamt[j]; f_in_dir = w5_dir[j]; j++;
            end else f_in_valid = 0;
            @(posedge clk); #1;
            if (c < 2) begin
                compared++; if (f_out_valid !== 1'b0) begin mismatched++; $display("FAIL w5_early_%0d got %b want 0", c, f_out_valid); end
            end
            if (f_out_valid) begin
                compared++;
                if (got >= 3) begin mismatched++; $display("FAIL w5_extra_beat got %b want none", f_out_data); end
                else if (f_out_data !== w5_exp[got]) begin mismatched++; $display("FAIL w5_%0d got %b want %b", got, f_out_data, w5_exp[got]); end
                got++;
            end
        end
        compared++; if (got != 3) begin mismatched++; $display("FAIL w5_count got %0d want 3", got); end
    endtask

`ifdef CYCLIC_SHIFT_XOR_ACC_EN
    task automatic test_xor_acc();
        logic [3:0] d [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        logic [3:0] e [4] = '{4'h1, 4'h3, 4'h7, 4'h8};
        int j = 0, got = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            if (j < 4) begin
                in_valid = 1; in_data = d[j]; in_shamt = 2'd0; in_last = (j == 2); j++;
            end else begin
                in_valid = 0; in_last = 0;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                compared++;
                if (got >= 4) begin mismatched++; $display("FAIL acc_extra_beat got %h want none", out_acc); end
                else if (out_acc !== e[got]) begin mismatched++; $display("FAIL acc_%0d got %h want %h", got, out_acc, e[got]); end
                got++;
            end
        end
        compared++; if (got != 4) begin mismatched++; $display("FAIL acc_count got %0d want 4", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_rotate();
        test_back_to_back();
        test_reset_flush();
        test_width5();
`ifdef CYCLIC_SHIFT_XOR_ACC_EN
        test_xor_acc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
